// File: rtl/clken_gen_pkg.sv
// Shared types and constants for the clken_gen clock-enable generator.
package clken_gen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_e;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/clken_acc.sv
// One clock-enable channel: phase accumulator with modulo wrap and a registered pulse.
module clken_acc #(
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned MODULUS = 1000000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic [ACC_W-1:0] inc_i,
    output logic             clken_o
);

    localparam logic [ACC_W:0] MOD_W = (ACC_W+1)'(MODULUS);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             clken_q, clken_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, inc_i};
        acc_d   = acc_q;
        clken_d = 1'b0;
        if (clr_i) begin
            acc_d = '0;
        end else if (adv_i) begin
            if (sum >= MOD_W) begin
                acc_d   = ACC_W'(sum - MOD_W);
                clken_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q   <= '0;
            clken_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            clken_q <= clken_d;
        end
    end

    assign clken_o = clken_q;

endmodule

// File: rtl/clken_gen.sv
// Multi-channel fractional clock-enable generator gated by a qualified PLL lock.
// Define CLKEN_GEN_RUNTIME_CFG_EN to make per-channel increments writable at runtime.
module clken_gen
    import clken_gen_pkg::*;
#(
    parameter int unsigned              NUM_CH      = 2,
    parameter int unsigned              ACC_W       = 24,
    parameter int unsigned              MODULUS     = 1000000,
    parameter logic [NUM_CH*ACC_W-1:0]  INC_INIT    = '0,
    parameter int unsigned              LOCK_CYCLES = 16
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic [NUM_CH-1:0] clken,
    output logic              ready
);

    localparam logic [ACC_W-1:0] MOD_M1   = ACC_W'(MODULUS - 1);
    localparam logic [15:0]      CNT_LAST = 16'(LOCK_CYCLES - 1);

    function automatic logic [ACC_W-1:0] sat_inc(input logic [ACC_W-1:0] v);
        return (v > MOD_M1) ? MOD_M1 : v;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock;
    state_e                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   ready_q;
    logic                   run_adv, run_clr;
    logic [ACC_W-1:0]       inc [NUM_CH];

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock) state_d = SETTLE;
            end
            SETTLE: begin
                if (!lock) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RUN: begin
                if (!lock) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // ready follows state_d so it is a register that matches state_q == RUN exactly
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == RUN);
        end
    end

    assign ready   = ready_q;
    assign run_adv = (state_q == RUN) && lock;
    assign run_clr = (state_q == RUN) && !lock;

`ifdef CLKEN_GEN_RUNTIME_CFG_EN
    logic [ACC_W-1:0] inc_q [NUM_CH];

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                inc_q[i] <= sat_inc(INC_INIT[i*ACC_W +: ACC_W]);
            end
        end else if (cfg_we) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (cfg_ch == 3'(i)) inc_q[i] <= sat_inc(cfg_inc);
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) inc[i] = inc_q[i];
    end
`else
    logic cfg_unused;
    assign cfg_unused = ^{cfg_we, cfg_ch, cfg_inc};

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) inc[i] = sat_inc(INC_INIT[i*ACC_W +: ACC_W]);
    end
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clken_acc #(
            .ACC_W   (ACC_W),
            .MODULUS (MODULUS)
        ) u_acc (
            .clk_i   (refclk),
            .rst_i   (rst),
            .clr_i   (run_clr),
            .adv_i   (run_adv && ch_en[i]),
            .inc_i   (inc[i]),
            .clken_o (clken[i])
        );
    end

endmodule

// File: tb/tb_clken_gen.sv
// Directed self-checking bench for clken_gen (MODULUS 1000, increments 184 / 499).
`timescale 1ns/1ps
module tb_clken_gen;

    localparam int unsigned NUM_CH      = 2;
    localparam int unsigned ACC_W       = 24;
    localparam int unsigned MODULUS     = 1000;
    localparam int unsigned LOCK_CYCLES = 16;
    localparam logic [NUM_CH*ACC_W-1:0] INC_INIT = {24'd499, 24'd184};

    logic              refclk = 1'b0;
    logic              rst;
    logic              pll_locked;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_we;
    logic [2:0]        cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [NUM_CH-1:0] clken;
    logic              ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] ch_en;
        logic [1:0] exp_clken;
        logic       exp_ready;
    } vec_t;

    vec_t vecs [13];

    always #5 refclk = ~refclk;

    clken_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .MODULUS     (MODULUS),
        .INC_INIT    (INC_INIT),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .ch_en      (ch_en),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .clken      (clken),
        .ready      (ready)
    );

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        if (!ready) n = -1;
    endtask

    initial begin
        int n, total, c0, c1, first0, viol;
        logic [1:0] prev;
        int exp_y [4];

        vecs[0]  = '{2'b11, 2'b00, 1'b1};
        vecs[1]  = '{2'b11, 2'b00, 1'b1};
        vecs[2]  = '{2'b11, 2'b00, 1'b1};
        vecs[3]  = '{2'b11, 2'b10, 1'b1};
        vecs[4]  = '{2'b11, 2'b00, 1'b1};
        vecs[5]  = '{2'b11, 2'b10, 1'b1};
        vecs[6]  = '{2'b11, 2'b01, 1'b1};
        vecs[7]  = '{2'b11, 2'b10, 1'b1};
        vecs[8]  = '{2'b11, 2'b00, 1'b1};
        vecs[9]  = '{2'b11, 2'b10, 1'b1};
        vecs[10] = '{2'b11, 2'b00, 1'b1};
        vecs[11] = '{2'b11, 2'b11, 1'b1};
        vecs[12] = '{2'b11, 2'b00, 1'b1};

        // reset overrides a high lock input
        rst = 1'b1; pll_locked = 1'b1; ch_en = 2'b11;
        cfg_we = 1'b0; cfg_ch = 3'd0; cfg_inc = '0;
        repeat (3) tick();
        check("reset ready", int'(ready), 0);
        check("reset clken", int'(clken), 0);
        rst = 1'b0; pll_locked = 1'b0;
        repeat (3) tick();
        check("idle ready", int'(ready), 0);

        // lock qualification: 2 sync + 16 settle + 1
        pll_locked = 1'b1;
        wait_ready(n);
        check("lock to ready cycles", n, 19);

        // one-cycle glitch at settle count 10 restarts qualification
        rst = 1'b1; pll_locked = 1'b0;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        pll_locked = 1'b1;
        repeat (11) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_ready(n);
        total = (n < 0) ? -1 : 12 + n;
        check("glitch lock to ready cycles", total, 31);

        // cycle-by-cycle pulse pattern from the ready edge
        for (int i = 0; i < 13; i++) begin
            if (i > 0) tick();
            check($sformatf("vec%0d clken", i), int'(clken), int'(vecs[i].exp_clken));
            check($sformatf("vec%0d ready", i), int'(ready), int'(vecs[i].exp_ready));
            ch_en = vecs[i].ch_en;
        end

        // lock loss: outputs off within 3 cycles, accumulators cleared
        pll_locked = 1'b0;
        repeat (3) tick();
        check("lockloss ready", int'(ready), 0);
        check("lockloss clken", int'(clken), 0);
        c0 = 0;
        repeat (5) begin
            tick();
            if (clken != 2'b00) c0++;
        end
        check("lockloss pulses", c0, 0);
        pll_locked = 1'b1;
        wait_ready(n);
        check("relock to ready cycles", n, 19);

        // long-run rate from cleared accumulators
        c0 = 0; c1 = 0; first0 = 0; viol = 0; prev = clken;
        for (int k = 1; k <= 10000; k++) begin
            tick();
            if (clken[0]) begin
                c0++;
                if (first0 == 0) first0 = k;
            end
            if (clken[1]) c1++;
            if ((clken & prev) != 2'b00) viol++;
            prev = clken;
        end
        check("first ch0 pulse after ready", first0, 6);
        check("ch0 pulses in 10000", c0, 1840);
        check("ch1 pulses in 10000", c1, 4990);
        check("multi-cycle pulses", viol, 0);

        // channel 1 disabled for 37 cycles, then resumes from held accumulator
        repeat (2) tick();
        ch_en = 2'b01;
        c0 = 0; c1 = 0;
        repeat (37) begin
            tick();
            if (clken[0]) c0++;
            if (clken[1]) c1++;
        end
        check("disabled ch1 pulses", c1, 0);
        check("ch0 pulses while ch1 off", c0, 7);
        ch_en = 2'b11;
        tick();
        check("resume clken", int'(clken), 2);

        // increment write coinciding with an advance
        tick();
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_inc = 24'd500;
`ifdef CLKEN_GEN_RUNTIME_CFG_EN
        exp_y = '{0, 1, 0, 1};
`else
        exp_y = '{0, 0, 1, 0};
`endif
        for (int j = 0; j < 4; j++) begin
            tick();
            cfg_we = 1'b0;
            check($sformatf("cfg write Y%0d clken0", j + 1), int'(clken[0]), exp_y[j]);
        end

        // out-of-range increment saturates to MODULUS-1
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_inc = 24'd2000;
        tick();
        cfg_we = 1'b0;
        c0 = 0;
        repeat (1000) begin
            tick();
            if (clken[0]) c0++;
        end
`ifdef CLKEN_GEN_RUNTIME_CFG_EN
        check("saturated inc ch0 pulses", c0, 999);
`else
        check("ignored cfg ch0 pulses", c0, 184);
`endif

        // reset mid-RUN overrides lock, ch_en and a concurrent cfg write
        rst = 1'b1; cfg_we = 1'b1; cfg_ch = 3'd0; cfg_inc = 24'd500;
        tick();
        check("midrun rst ready", int'(ready), 0);
        check("midrun rst clken", int'(clken), 0);
        rst = 1'b0; cfg_we = 1'b0;
        wait_ready(n);
        check("post-rst lock to ready cycles", n, 19);

        // cfg_ch beyond NUM_CH is ignored; increments back at INC_INIT
        cfg_we = 1'b1; cfg_ch = 3'd5; cfg_inc = 24'd10;
        c0 = 0; c1 = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            cfg_we = 1'b0;
            if (clken[0]) c0++;
            if (clken[1]) c1++;
        end
        check("cfg_ch5 ch0 pulses", c0, 18);
        check("cfg_ch5 ch1 pulses", c1, 49);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
